// File: rtl/debug_reg_dumper.sv
// debug_reg_dumper
//   Freezes the pipeline and streams every register of the decode-stage
//   register bank out as bytes, MSB first, four bytes per register.
//   A dump_req dump resumes the pipeline afterwards. A program_end dump
//   leaves it halted, and a later dump_req can dump it again.
//
// state  | meaning
// IDLE   | pipeline running, waiting for a request
// READ   | index presented on o_reg_read, waiting READ_LATENCY cycles
// LOAD   | capture i_reg_content into the shift register
// SEND   | present shift[31:24] until four bytes are accepted
// DONE   | one-cycle completion pulse
// HALTED | dump finished after program end, pipeline stays frozen
//
// Ports
//   i_clk, i_reset        clock, async active-high reset
//   i_dump_req            dump request, resume afterwards
//   i_program_end         dump request, stay halted afterwards
//   o_halt                pipeline freeze
//   o_reg_read            register index toward the debug read port
//   i_reg_content         register value for o_reg_read
//   o_tx_data/o_tx_valid  byte stream toward the transmitter
//   i_tx_ready            transmitter accepts the byte this cycle
//   o_busy                dump in progress (READ, LOAD or SEND)
//   o_done                last byte of the dump accepted
module debug_reg_dumper #(
  parameter int NUM_REGS     = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dump_req,
  input  logic        i_program_end,
  output logic        o_halt,
  output logic [4:0]  o_reg_read,
  input  logic [31:0] i_reg_content,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);
  // Down-counter preset so READ lasts exactly READ_LATENCY cycles.
  localparam logic [2:0] LAT_PRESET = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    SEND,
    DONE,
    HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  byte_q, byte_d;
  logic        src_pe_q, src_pe_d;  // 1: dump was started by program end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      idx_q    <= 5'd0;
      lat_q    <= 3'd0;
      shift_q  <= 32'd0;
      byte_q   <= 2'd0;
      src_pe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      src_pe_q <= src_pe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    src_pe_d = src_pe_q;

    case (state_q)
      IDLE: begin
        if (i_dump_req || i_program_end) begin
          state_d  = READ;
          idx_d    = 5'd0;
          lat_d    = LAT_PRESET;
          src_pe_d = i_program_end;
        end
      end
      HALTED: begin
        // program_end is ignored here; the source stays program_end so a
        // re-dump comes back to HALTED.
        if (i_dump_req) begin
          state_d = READ;
          idx_d   = 5'd0;
          lat_d   = LAT_PRESET;
        end
      end
      READ: begin
        if (lat_q == 3'd0) begin
          state_d = LOAD;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      LOAD: begin
        shift_d = i_reg_content;
        byte_d  = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        if (i_tx_ready) begin
          shift_d = {shift_q[23:0], 8'h00};
          byte_d  = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 5'd1;
              lat_d   = LAT_PRESET;
              state_d = READ;
            end
          end
        end
      end
      DONE: begin
        state_d = src_pe_q ? HALTED : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state so reset clears them
  // without waiting for a clock edge.
  assign o_halt     = (state_q != IDLE);
  assign o_busy     = (state_q == READ) || (state_q == LOAD) || (state_q == SEND);
  assign o_done     = (state_q == DONE);
  assign o_tx_valid = (state_q == SEND);
  assign o_tx_data  = shift_q[31:24];
  assign o_reg_read = idx_q;

endmodule

// File: tb/tb_debug_reg_dumper.sv
module tb_debug_reg_dumper;

  logic        clk = 1'b0;
  logic        rst;

  logic        dump_req, prog_end, tx_ready;
  logic        halt, tx_valid, busy, done;
  logic [4:0]  reg_read;
  logic [31:0] reg_content;
  logic [7:0]  tx_data;

  logic        dump_req3, prog_end3, tx_ready3;
  logic        halt3, tx_valid3, busy3, done3;
  logic [4:0]  reg_read3;
  logic [31:0] reg_content3, b1, b2, b3;
  logic [7:0]  tx_data3;

  int n_checks = 0;
  int n_pass   = 0;
  int xfers    = 0;
  int xfers3   = 0;
  int pat      = 0;
  logic [7:0] q1[$];
  logic [7:0] q3[$];
  logic [7:0] mon_exp, mon_exp3;

  always #5 clk = ~clk;

  debug_reg_dumper #(.NUM_REGS(32), .READ_LATENCY(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_dump_req(dump_req), .i_program_end(prog_end),
    .o_halt(halt), .o_reg_read(reg_read), .i_reg_content(reg_content),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_done(done)
  );

  debug_reg_dumper #(.NUM_REGS(32), .READ_LATENCY(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_dump_req(dump_req3), .i_program_end(prog_end3),
    .o_halt(halt3), .o_reg_read(reg_read3), .i_reg_content(reg_content3),
    .o_tx_data(tx_data3), .o_tx_valid(tx_valid3), .i_tx_ready(tx_ready3),
    .o_busy(busy3), .o_done(done3)
  );

  function automatic logic [31:0] bank_word(int p, int k);
    if (p == 0) return 32'h1000_0000 + 32'(k);
    return {8'hA0 + 8'(k), 8'h50 + 8'(k), 8'hC0 + 8'(k), 8'h20 + 8'(k)};
  endfunction

  function automatic logic [31:0] bank3_word(int k);
    return {8'h3C, 8'(k), 8'h99 ^ 8'(k), 8'(k * 7 + 1)};
  endfunction

  // Bank for dut: combinational read. Bank for dut3: three-cycle read pipe.
  assign reg_content = bank_word(pat, int'(reg_read));
  always @(posedge clk) begin
    b1 <= bank3_word(int'(reg_read3));
    b2 <= b1;
    b3 <= b2;
  end
  assign reg_content3 = b3;

  // Scoreboards: a byte transfers on the next rising edge when valid and
  // ready are both high at the falling edge.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      n_checks++;
      if (q1.size() == 0) begin
        $display("FAIL tx_byte: got %02h, no byte expected", tx_data);
      end else begin
        mon_exp = q1.pop_front();
        if (tx_data !== mon_exp)
          $display("FAIL tx_byte #%0d: got %02h want %02h", xfers, tx_data, mon_exp);
        else n_pass++;
      end
      xfers++;
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_valid3 && tx_ready3) begin
      n_checks++;
      if (q3.size() == 0) begin
        $display("FAIL tx_byte_lat3: got %02h, no byte expected", tx_data3);
      end else begin
        mon_exp3 = q3.pop_front();
        if (tx_data3 !== mon_exp3)
          $display("FAIL tx_byte_lat3 #%0d: got %02h want %02h", xfers3, tx_data3, mon_exp3);
        else n_pass++;
      end
      xfers3++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(int p);
    logic [31:0] w;
    for (int k = 0; k < 32; k++) begin
      w = bank_word(p, k);
      for (int b = 3; b >= 0; b--) q1.push_back(w[b*8 +: 8]);
    end
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({halt, tx_valid, busy, done} !== 4'b0000)
      $display("FAIL reset_flags: got halt/valid/busy/done=%b want 0000", {halt, tx_valid, busy, done});
    else n_pass++;
    n_checks++;
    if (reg_read !== 5'd0) $display("FAIL reset_reg_read: got %0d want 0", reg_read);
    else n_pass++;
    n_checks++;
    if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %02h want 00", tx_data);
    else n_pass++;
    n_checks++;
    if ({halt3, tx_valid3, busy3, done3} !== 4'b0000)
      $display("FAIL reset_flags_lat3: got %b want 0000", {halt3, tx_valid3, busy3, done3});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_dump();
    int edges, done_edge, done_cycles;
    pat = 0; tx_ready = 1'b1; xfers = 0;
    push_dump(0);
    tick();
    dump_req = 1'b1;
    edges = 0; done_edge = 0; done_cycles = 0;
    while (edges < 400) begin
      tick();
      edges++;
      if (edges == 1) dump_req = 1'b0;
      if (done) begin
        done_cycles++;
        if (done_edge == 0) done_edge = edges;
      end
      if (done_edge != 0 && edges > done_edge + 3) break;
    end
    n_checks++;
    if (done_edge !== 193) $display("FAIL full_done_edge: got %0d want 193", done_edge);
    else n_pass++;
    n_checks++;
    if (done_cycles !== 1) $display("FAIL full_done_width: got %0d want 1", done_cycles);
    else n_pass++;
    n_checks++;
    if ({halt, busy} !== 2'b00) $display("FAIL full_idle: got halt/busy=%b want 00", {halt, busy});
    else n_pass++;
    n_checks++;
    if (xfers !== 128 || q1.size() !== 0)
      $display("FAIL full_count: got %0d bytes, %0d left want 128, 0", xfers, q1.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc;
    bit stalled, stable;
    logic [7:0] hold;
    logic [31:0] w;
    pat = 1; xfers = 0; tx_ready = 1'b0;
    push_dump(1);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    stalled = 0; cyc = 0; hold = 8'h00;
    while (!done && cyc < 3000) begin
      if (!stalled && xfers == 21 && tx_valid) begin
        hold = tx_data; tx_ready = 1'b0; stable = 1;
        for (int i = 0; i < 10; i++) begin
          tick(); cyc++;
          if (tx_data !== hold || tx_valid !== 1'b1) stable = 0;
        end
        w = bank_word(1, 5);
        n_checks++;
        if (!stable) $display("FAIL stall_stable: data changed, held %02h now %02h", hold, tx_data);
        else n_pass++;
        n_checks++;
        if (hold !== w[23:16]) $display("FAIL stall_byte: got %02h want %02h", hold, w[23:16]);
        else n_pass++;
        stalled = 1;
      end else begin
        tx_ready = ~tx_ready;
      end
      tick(); cyc++;
    end
    n_checks++;
    if (!stalled || !done) $display("FAIL bp_complete: stalled=%0d done=%b want 1 1", stalled, done);
    else n_pass++;
    n_checks++;
    if (xfers !== 128 || q1.size() !== 0)
      $display("FAIL bp_count: got %0d bytes, %0d left want 128, 0", xfers, q1.size());
    else n_pass++;
    tx_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_program_end();
    int cyc;
    pat = 0; tx_ready = 1'b1; xfers = 0;
    push_dump(0);
    prog_end = 1'b1;
    tick();
    prog_end = 1'b0;
    wait_done(1000, cyc);
    n_checks++;
    if (!done) $display("FAIL pe_done: got no done within %0d cycles", cyc);
    else n_pass++;
    tick();
    n_checks++;
    if ({halt, busy, done} !== 3'b100) $display("FAIL pe_halted: got halt/busy/done=%b want 100", {halt, busy, done});
    else n_pass++;
    prog_end = 1'b1;
    tick();
    prog_end = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (busy !== 1'b0 || halt !== 1'b1 || xfers !== 128)
      $display("FAIL pe_ignored: got busy=%b halt=%b bytes=%0d want 0 1 128", busy, halt, xfers);
    else n_pass++;
    xfers = 0;
    push_dump(0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_done(1000, cyc);
    repeat (3) tick();
    n_checks++;
    if ({halt, busy} !== 2'b10 || xfers !== 128 || q1.size() !== 0)
      $display("FAIL pe_redump: got halt/busy=%b bytes=%0d left=%0d want 10 128 0", {halt, busy}, xfers, q1.size());
    else n_pass++;
    do_reset();
  endtask

  task automatic test_simultaneous_late();
    int cyc;
    xfers = 0;
    push_dump(0);
    dump_req = 1'b1; prog_end = 1'b1;
    tick();
    dump_req = 1'b0; prog_end = 1'b0;
    wait_done(1000, cyc);
    repeat (5) tick();
    n_checks++;
    if ({halt, busy} !== 2'b10) $display("FAIL both_req_halted: got halt/busy=%b want 10", {halt, busy});
    else n_pass++;
    do_reset();
    xfers = 0;
    push_dump(0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    cyc = 0;
    while (!tx_valid && cyc < 20) begin
      tick(); cyc++;
    end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_done(1000, cyc);
    repeat (20) tick();
    n_checks++;
    if ({halt, busy} !== 2'b00 || xfers !== 128 || q1.size() !== 0)
      $display("FAIL late_req: got halt/busy=%b bytes=%0d left=%0d want 00 128 0", {halt, busy}, xfers, q1.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    xfers = 0;
    push_dump(0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    cyc = 0;
    while (!(reg_read == 5'd17 && tx_valid) && cyc < 2000) begin
      tick(); cyc++;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({tx_valid, halt, busy} !== 3'b000)
      $display("FAIL async_reset: got valid/halt/busy=%b want 000", {tx_valid, halt, busy});
    else n_pass++;
    q1.delete();
    n_checks++;
    if (xfers !== 68) $display("FAIL reset_point: got %0d bytes before reset want 68", xfers);
    else n_pass++;
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b0;
    push_dump(0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n_checks++;
    if (reg_read !== 5'd0 || busy !== 1'b1)
      $display("FAIL restart: got reg_read=%0d busy=%b want 0 1", reg_read, busy);
    else n_pass++;
    wait_done(1000, cyc);
    tick();
    n_checks++;
    if (xfers !== 196 || q1.size() !== 0)
      $display("FAIL restart_count: got %0d bytes, %0d left want 196, 0", xfers, q1.size());
    else n_pass++;
  endtask

  task automatic test_latency();
    int edges, last, done_edge;
    logic [4:0] prev;
    logic [31:0] w;
    tx_ready3 = 1'b1; xfers3 = 0;
    for (int k = 0; k < 32; k++) begin
      w = bank3_word(k);
      for (int b = 3; b >= 0; b--) q3.push_back(w[b*8 +: 8]);
    end
    tick();
    dump_req3 = 1'b1;
    edges = 0; last = 0; done_edge = 0; prev = 5'd0;
    while (edges < 600) begin
      tick();
      edges++;
      if (edges == 1) begin
        dump_req3 = 1'b0;
        last = 1;
      end
      if (busy3 && reg_read3 !== prev) begin
        n_checks++;
        if (edges - last !== 8)
          $display("FAIL lat3_period reg %0d: got %0d cycles want 8", prev, edges - last);
        else n_pass++;
        last = edges;
        prev = reg_read3;
      end
      if (done3) begin
        done_edge = edges;
        break;
      end
    end
    n_checks++;
    if (done_edge !== 257) $display("FAIL lat3_done_edge: got %0d want 257", done_edge);
    else n_pass++;
    n_checks++;
    if (xfers3 !== 128 || q3.size() !== 0)
      $display("FAIL lat3_count: got %0d bytes, %0d left want 128, 0", xfers3, q3.size());
    else n_pass++;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    dump_req = 1'b0; prog_end = 1'b0; tx_ready = 1'b1;
    dump_req3 = 1'b0; prog_end3 = 1'b0; tx_ready3 = 1'b1;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_program_end();
    test_simultaneous_late();
    test_reset_mid();
    test_latency();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/debug_reg_dumper.md
DEBUG_REG_DUMPER -- requirements
Module: debug_reg_dumper

Interface
REQ-001 Parameter NUM_REGS, default 32: number of registers dumped, indices 0..NUM_REGS-1.
REQ-002 Parameter READ_LATENCY, default 1: cycles o_reg_read is held before i_reg_content is sampled; legal values 1..7.
REQ-003 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_dump_req  in  1  one-cycle request to dump the register bank and then resume.
REQ-006 i_program_end  in  1  end-of-program flag from the decode stage; dump, then stay halted.
REQ-007 o_halt  out  1  pipeline freeze; drives the decode stage halt input.
REQ-008 o_reg_read  out  5  register index presented to the decode-stage debug read port.
REQ-009 i_reg_content  in  32  register value returned for o_reg_read.
REQ-010 o_tx_data  out  8  byte toward the serial transmitter.
REQ-011 o_tx_valid  out  1  o_tx_data is valid.
REQ-012 i_tx_ready  in  1  transmitter accepts the byte this cycle.
REQ-013 o_busy  out  1  a dump is in progress (state not IDLE, HALTED or DONE).
REQ-014 o_done  out  1  one-cycle pulse when the last byte of a dump is accepted.

Function
REQ-015 FSM states SHALL be IDLE, READ, LOAD, SEND, DONE and HALTED.
REQ-016 IDLE: when i_dump_req or i_program_end is sampled high, the block SHALL go to READ with index 0 and latch the source (program_end wins if both are high).
REQ-017 o_halt SHALL be 1 in every state except IDLE.
REQ-018 READ: o_reg_read SHALL equal the current index; the block SHALL stay in READ exactly READ_LATENCY cycles, then go to LOAD.
REQ-019 LOAD: the block SHALL capture i_reg_content into a 32-bit shift register, clear the byte counter and go to SEND, all in one cycle.
REQ-020 SEND: o_tx_valid SHALL be 1; o_tx_data SHALL be shift[31:24] (MSB first); a byte transfers on any cycle with o_tx_valid and i_tx_ready both high.
REQ-021 While o_tx_valid=1 and i_tx_ready=0, o_tx_data SHALL hold stable.
REQ-022 On each transfer the block SHALL shift left by 8 and increment the 2-bit byte counter.
REQ-023 On the 4th transfer: if index equals NUM_REGS-1, the block SHALL go to DONE; otherwise it SHALL increment the index and go to READ.
REQ-024 DONE SHALL last one cycle with o_done=1, then go to IDLE for a dump_req source or HALTED for a program_end source.
REQ-025 HALTED: o_halt SHALL stay 1; i_dump_req SHALL start a new dump (source kept as program_end); i_program_end SHALL be ignored.
REQ-026 Requests arriving in READ, LOAD, SEND or DONE SHALL be ignored and SHALL NOT be queued.
REQ-027 The index SHALL never exceed NUM_REGS-1 and SHALL NOT wrap.
REQ-028 o_tx_valid SHALL be 0 in every state except SEND.
REQ-029 Per register with i_tx_ready tied high, the dump SHALL take READ_LATENCY+5 cycles.

Reset
REQ-030 While i_reset=1, the block SHALL immediately and asynchronously enter IDLE.
REQ-031 Under reset, o_halt, o_tx_valid, o_busy and o_done SHALL be 0, o_reg_read SHALL be 5'd0, o_tx_data SHALL be 8'h00, and the index, byte counter, shift register and source SHALL be cleared.
REQ-032 Reset asserted mid-dump SHALL abort the dump with no further transfers; the first rising edge after release SHALL find the block in IDLE.

Verification
REQ-033 Full dump: register k = 32'h1000_0000+k, READ_LATENCY=1, i_tx_ready=1, one i_dump_req pulse -> 128 bytes sent, starting 10 00 00 00, 10 00 00 01 and ending 10 00 00 1F. o_done is high for exactly one cycle, entered on the 193rd edge after the request edge. o_halt then falls and the state is IDLE.
REQ-034 Backpressure: i_tx_ready alternates 0/1, then is held 0 for 10 cycles during byte 2 of register 5 -> o_tx_data stays constant while stalled, and no byte is duplicated or dropped.
REQ-035 Program end: i_program_end=1 -> the full dump runs, o_done pulses, and o_halt stays 1 in HALTED. A later i_dump_req runs a second dump and the block returns to HALTED.
REQ-036 Simultaneous and late requests: i_dump_req and i_program_end high in the same cycle -> the block ends in HALTED. An i_dump_req pulse during SEND produces no second dump.
REQ-037 Reset mid-dump: i_reset asserted during SEND of register 17 -> o_tx_valid, o_halt and o_busy go to 0 without waiting for a clock edge. A new request after release restarts at register 0.
REQ-038 Latency: READ_LATENCY=3 with a bank model of 3-cycle read latency -> every captured value matches its register, and each register takes 8 cycles with i_tx_ready=1.
